// File: rtl/tt_um_serial_sub_if.sv
// Operand/status bus of the bit-serial subtractor tile.
// master drives operands and strobes, slave returns the result and status.
interface tt_um_serial_sub_if;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (
      output ui_in, uio_in,
      input  uo_out, uio_out, uio_oe
   );

   modport slave (
      input  ui_in, uio_in,
      output uo_out, uio_out, uio_oe
   );
endinterface

// File: rtl/tt_um_serial_sub.sv
// Bit-serial A - B - Bin, LSB first, one full-subtractor cell per clock.
// Define SERSUB_SIGNED_OVF_EN to add signed overflow on uio_out[4].
module tt_um_serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
   logic [WIDTH-1:0] diff_q, diff_d, diff_nxt;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             borrow_q, borrow_d, brw_nxt, d_bit;
   logic [7:0]       res_q, res_d;
   logic             bout_q, bout_d;
   logic             ld_a, ld_b, start, bin;
   logic             busy, done, ovf;
`ifdef SERSUB_SIGNED_OVF_EN
   logic             ovf_q, ovf_d, amsb_q, amsb_d, bmsb_q, bmsb_d;
`endif

   logic unused_ok;
   assign unused_ok = &{1'b0, ena, uio_in[7:4], ui_in};

   assign ld_a  = uio_in[0];
   assign ld_b  = uio_in[1];
   assign start = uio_in[2];
   assign bin   = uio_in[3];

   assign d_bit    = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
   assign brw_nxt  = (~a_sh_q[0] & b_sh_q[0])
                   | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
   assign diff_nxt = {d_bit, diff_q[WIDTH-1:1]};

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      res_d    = res_q;
      bout_d   = bout_q;
`ifdef SERSUB_SIGNED_OVF_EN
      ovf_d    = ovf_q;
      amsb_d   = amsb_q;
      bmsb_d   = bmsb_q;
`endif
      unique case (state_q)
         RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            diff_d   = diff_nxt;
            borrow_d = brw_nxt;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               res_d   = 8'(diff_nxt);
               bout_d  = brw_nxt;
               state_d = DONE;
`ifdef SERSUB_SIGNED_OVF_EN
               ovf_d   = (amsb_q != bmsb_q) && (d_bit != amsb_q);
`endif
            end
         end
         default: begin
            // loads land before start so a same-edge load feeds the shifters
            if (ld_a) a_d = ui_in[WIDTH-1:0];
            if (ld_b) b_d = ui_in[WIDTH-1:0];
            if (start) begin
               a_sh_d   = a_d;
               b_sh_d   = b_d;
               diff_d   = '0;
               borrow_d = bin;
               cnt_d    = '0;
               state_d  = RUN;
`ifdef SERSUB_SIGNED_OVF_EN
               ovf_d    = 1'b0;
               amsb_d   = a_d[WIDTH-1];
               bmsb_d   = b_d[WIDTH-1];
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         res_q    <= '0;
         bout_q   <= 1'b0;
`ifdef SERSUB_SIGNED_OVF_EN
         ovf_q    <= 1'b0;
         amsb_q   <= 1'b0;
         bmsb_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         res_q    <= res_d;
         bout_q   <= bout_d;
`ifdef SERSUB_SIGNED_OVF_EN
         ovf_q    <= ovf_d;
         amsb_q   <= amsb_d;
         bmsb_q   <= bmsb_d;
`endif
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

`ifdef SERSUB_SIGNED_OVF_EN
   assign ovf    = ovf_q;
   assign uio_oe = 8'hF0;
`else
   assign ovf    = 1'b0;
   assign uio_oe = 8'hE0;
`endif

   assign uo_out  = res_q;
   assign uio_out = {busy, done, bout_q, ovf, 4'b0000};
endmodule

// File: doc/tt_um_serial_sub.md
Name: tt_um_serial_sub

Overview:
- Bit-serial subtractor: computes A − B − Bin one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow.
- It is the inverse-arithmetic counterpart to our combinational half-adder tile.
- Sits as a standalone Tiny Tapeout user tile on the standard tt_um pin frame.
- Operands are loaded byte-wide over ui_in under strobe control; result and status are reported on uo_out / uio_out.

Parameters:
- WIDTH, 8, operand/result width in bits. Legal range 2..8. Result is zero-extended onto uo_out[7:0]. Operand loads use ui_in[WIDTH-1:0].

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- ena  input  1  always 1 when powered; ignored
- ui_in  input  8  operand data bus
- uio_in  input  8  [0] load_a, [1] load_b, [2] start, [3] borrow_in, [7:4] unused
- uo_out  output  8  registered difference (zero-extended)
- uio_out  output  8  [7] busy, [6] done, [5] borrow_out, [4] ovf (optional feature), [3:0] = 0
- uio_oe  output  8  constant 8'hE0 (8'hF0 when the optional feature is enabled)

Behaviour:
- Reset is synchronous and active-low: any rising clk edge with rst_n=0 does the following, and this aborts an operation in progress:
  - state=IDLE
  - a_reg, b_reg, shift registers, diff, cnt, borrow, uo_out all = 0
  - busy=0, done=0, borrow_out=0, ovf=0
- State machine (IDLE, RUN, DONE):
  - IDLE/DONE:
    - load_a=1 → a_reg<=ui_in[WIDTH-1:0]; load_b=1 → b_reg<=ui_in[WIDTH-1:0]. Both may load in the same cycle.
    - start=1 → copy operands into shift registers (a_sh, b_sh), borrow<=borrow_in, cnt<=0, done<=0, busy<=1, state<=RUN.
    - If load and start are sampled on the same edge, the newly loaded operand values are used.
    - a_reg and b_reg are preserved across operations, so start without a reload recomputes the same result.
  - RUN (each cycle):
    - d = a_sh[0]^b_sh[0]^borrow
    - borrow <= (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&borrow)
    - a_sh and b_sh shift right by one; d shifts into the MSB of diff; cnt++
    - load_a, load_b and start are ignored.
  - After the WIDTH-th bit: uo_out<=final diff, borrow_out<=final borrow, busy<=0, done<=1, state<=DONE.
- Latency: start sampled at edge k → busy high for edges k+1..k+WIDTH; done and result visible after edge k+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- Outputs:
  - done is sticky until the next accepted start.
  - uo_out holds its value until the next completion or reset; it never shows partial results.
  - borrow_out=1 means the unsigned result underflowed (A < B+Bin).
- Width rules:
  - Arithmetic is modulo 2^WIDTH.
  - ui_in bits above WIDTH-1 are ignored.
  - uo_out[7:WIDTH]=0.
- Wrap-around: cnt width is clog2(WIDTH)+1; RUN terminates exactly at cnt==WIDTH-1 processed.

Optional Feature:
- Macro SERSUB_SIGNED_OVF_EN.
- Defined:
  - uio_out[4] = signed two's-complement overflow of the final result: (a_msb != b_msb) && (d_msb != a_msb), where d_msb is the last computed bit, using the operand MSBs captured at start.
  - ovf is registered with the result, reset to 0, and cleared on start.
  - uio_oe = 8'hF0.
- Undefined: uio_out[4]=0, uio_oe=8'hE0, no overflow logic present.

Test Plan:
- Reset held 2 cycles → uo_out=0x00, uio_out=0x00, uio_oe=0xE0 (0xF0 with macro); busy/done low.
- Load A=0x5A, B=0x23, start, Bin=0 → busy high 8 cycles, then done=1, uo_out=0x37, borrow_out=0.
- A=0x10, B=0x20 → uo_out=0xF0, borrow_out=1, ovf=0. Then start again without reload → identical result 0xF0.
- A=0x00, B=0x00, Bin=1 → uo_out=0xFF, borrow_out=1. With macro: A=0x80, B=0x01, Bin=0 → uo_out=0x7F, borrow_out=0, ovf=1.
- During RUN pulse load_a with 0xFF and start → ignored; result still matches the original operands. Load and start on the same edge → new operand used.
- Assert rst_n=0 on the 3rd RUN cycle → next cycle all outputs 0, state IDLE. Reload A=0x09, B=0x04 and run → uo_out=0x05.
